// File: rtl/ppu_pkg.sv
// Shared PPU types and constants.
// pixel_t   : one FIFO entry {bg_priority, palette, color[1:0]}.
// COLOR_TRANSPARENT : colour index that lets a later sprite show through.
// PPU_ROW_PIXELS / PPU_FIFO_DEPTH : default tile-row width and FIFO depth.
package ppu_pkg;

  typedef struct packed {
    logic       bg_priority;
    logic       palette;
    logic [1:0] color;
  } pixel_t;

  localparam logic [1:0] COLOR_TRANSPARENT = 2'd0;
  localparam int         PIXEL_W           = $bits(pixel_t);
  localparam int         PPU_ROW_PIXELS    = 8;
  localparam int         PPU_FIFO_DEPTH    = 16;

endpackage

// File: rtl/pixel_fifo_if.sv
// Pixel FIFO bus between the PPU fetcher / LCD pixel stage (master) and the
// FIFO (slave).
// clear, push_valid/push_data, merge_en/merge_data, pop_en : master -> FIFO
// push_ready, pop_data, pop_valid, count                    : FIFO -> master
interface pixel_fifo_if
  import ppu_pkg::*;
#(
  parameter int DataWidth = PIXEL_W,
  parameter int PushWidth = PPU_ROW_PIXELS,
  parameter int Depth     = PPU_FIFO_DEPTH
);
  localparam int CntW = $clog2(Depth + 1);

  logic                           clear;
  logic                           push_valid;
  logic [PushWidth*DataWidth-1:0] push_data;
  logic                           push_ready;
  logic                           merge_en;
  logic [PushWidth*DataWidth-1:0] merge_data;
  logic                           pop_en;
  logic [DataWidth-1:0]           pop_data;
  logic                           pop_valid;
  logic [CntW-1:0]                count;

  modport master (
    output clear, push_valid, push_data, merge_en, merge_data, pop_en,
    input  push_ready, pop_data, pop_valid, count
  );

  modport slave (
    input  clear, push_valid, push_data, merge_en, merge_data, pop_en,
    output push_ready, pop_data, pop_valid, count
  );

endinterface

// File: rtl/pixel_fifo_merge_lane.sv
// One lane of the sprite-overlay merge (combinational).
// existing : entry currently in the FIFO slot
// incoming : sprite pixel for this slot
// in_range : slot holds a live entry (lane index < post-pop count)
// merged   : entry to write back; a live opaque entry is kept, so the
//            first sprite to claim a pixel wins.
module pixel_merge_lane
  import ppu_pkg::*;
#(
  parameter int DataWidth = PIXEL_W,
  parameter int ColorBits = 2
) (
  input  logic [DataWidth-1:0] existing,
  input  logic [DataWidth-1:0] incoming,
  input  logic                 in_range,
  output logic [DataWidth-1:0] merged
);

  logic transparent;

  assign transparent = existing[ColorBits-1:0] == ColorBits'(COLOR_TRANSPARENT);
  assign merged      = (in_range && !transparent) ? existing : incoming;

endmodule

// File: rtl/pixel_fifo.sv
// Pixel FIFO for the PPU draw pipeline (background or sprite instance).
// clk, rstN : clock, async active-low reset
// bus       : slave side of pixel_fifo_if -- bulk row push, single-pixel
//             show-ahead pop, synchronous clear and sprite-row merge onto
//             the head. Precedence: clear > merge > push; pop combines with
//             push or merge in the same cycle.
module pixel_fifo
  import ppu_pkg::*;
#(
  parameter int DataWidth = PIXEL_W,
  parameter int ColorBits = 2,
  parameter int Depth     = PPU_FIFO_DEPTH,
  parameter int PushWidth = PPU_ROW_PIXELS
) (
  input  logic         clk,
  input  logic         rstN,
  pixel_fifo_if.slave  bus
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  typedef logic [DataWidth-1:0] entry_t;

  entry_t                              mem_q [Depth];
  entry_t                              mem_d [Depth];
  logic   [PtrW-1:0]                   head_q, head_d, tail_q, tail_d;
  logic   [CntW-1:0]                   count_q, count_d;
  logic   [PtrW-1:0]                   head_pop;
  logic   [CntW-1:0]                   cnt_pop, cnt_merge;
  logic                                pop_fire, push_fire;
  logic   [PushWidth-1:0][DataWidth-1:0] lane_out;

  assign pop_fire  = bus.pop_en && (count_q != '0);
  assign head_pop  = head_q + PtrW'(pop_fire);
  assign cnt_pop   = count_q - CntW'(pop_fire);
  // Space is judged on pre-pop occupancy: a same-cycle pop never makes room.
  assign bus.push_ready = ((CntW'(Depth) - count_q) >= CntW'(PushWidth)) && !bus.merge_en;
  assign push_fire = bus.push_valid && bus.push_ready;
  assign cnt_merge = (cnt_pop > CntW'(PushWidth)) ? cnt_pop : CntW'(PushWidth);

  assign bus.pop_valid = count_q != '0;
  assign bus.pop_data  = bus.pop_valid ? mem_q[head_q] : '0;
  assign bus.count     = count_q;

  // Merge lanes look at the slots starting from the post-pop head.
  for (genvar i = 0; i < PushWidth; i++) begin : g_lane
    pixel_merge_lane #(
      .DataWidth(DataWidth),
      .ColorBits(ColorBits)
    ) u_lane (
      .existing (mem_q[head_pop + PtrW'(i)]),
      .incoming (bus.merge_data[i*DataWidth +: DataWidth]),
      .in_range (CntW'(i) < cnt_pop),
      .merged   (lane_out[i])
    );
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_pop;
    tail_d  = tail_q;
    count_d = cnt_pop;
    if (bus.clear) begin
      // Contents are left in place; only the pointers are flushed.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (bus.merge_en) begin
      for (int i = 0; i < PushWidth; i++)
        mem_d[head_pop + PtrW'(i)] = lane_out[i];
      count_d = cnt_merge;
      tail_d  = head_pop + PtrW'(cnt_merge);  // wraps modulo Depth
    end else if (push_fire) begin
      for (int i = 0; i < PushWidth; i++)
        mem_d[tail_q + PtrW'(i)] = bus.push_data[i*DataWidth +: DataWidth];
      tail_d  = tail_q + PtrW'(PushWidth);
      count_d = cnt_pop + CntW'(PushWidth);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is readable until it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_pixel_fifo.sv
module tb_pixel_fifo;

  logic clk = 1'b0;
  logic rstN;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pixel_fifo_if #(.DataWidth(4), .PushWidth(8), .Depth(16)) bus ();

  pixel_fifo #(.DataWidth(4), .ColorBits(2), .Depth(16), .PushWidth(8)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  task automatic idle();
    bus.clear      = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.merge_en   = 1'b0;
    bus.merge_data = '0;
    bus.pop_en     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] seq_row(input int base);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = 4'(base + i);
    return r;
  endfunction

  task automatic test_reset();
    rstN = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid got=%b exp=0", bus.pop_valid); end
    checks++; if (bus.pop_data !== 4'h0) begin failures++; $display("FAIL reset_pop_data got=%h exp=0", bus.pop_data); end
    checks++; if (bus.push_ready !== 1'b1) begin failures++; $display("FAIL reset_push_ready got=%b exp=1", bus.push_ready); end
    bus.pop_en = 1'b1;
    tick();
    bus.pop_en = 1'b0;
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", bus.count); end
    checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL empty_pop_valid got=%b exp=0", bus.pop_valid); end
  endtask

  task automatic test_fill();
    bus.push_valid = 1'b1;
    bus.push_data  = 32'h7654_3210;
    tick();
    bus.push_data  = 32'hFEDC_BA98;
    tick();
    checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", bus.count); end
    checks++; if (bus.push_ready !== 1'b0) begin failures++; $display("FAIL fill_push_ready got=%b exp=0", bus.push_ready); end
    bus.push_data  = 32'h5555_5555;
    tick();
    bus.push_valid = 1'b0;
    checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL full_drop_count got=%0d exp=16", bus.count); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus.pop_data !== 4'(k)) begin failures++; $display("FAIL fill_pop[%0d] got=%h exp=%h", k, bus.pop_data, 4'(k)); end
      bus.pop_en = 1'b1;
      tick();
    end
    bus.pop_en = 1'b0;
    checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL drain_pop_valid got=%b exp=0", bus.pop_valid); end
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_stream();
    int mcount;
    int next_push;
    int exp_val;
    bus.push_valid = 1'b1;
    bus.push_data  = seq_row(0);
    tick();
    next_push = 8;
    mcount    = 8;
    exp_val   = 0;
    for (int c = 0; c < 64; c++) begin
      checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== 4'(exp_val)) begin
        failures++;
        $display("FAIL stream_pop[%0d] got=%h/%b exp=%h/1", c, bus.pop_data, bus.pop_valid, 4'(exp_val));
      end
      bus.pop_en = 1'b1;
      if (mcount <= 8) begin
        bus.push_valid = 1'b1;
        bus.push_data  = seq_row(next_push);
        next_push += 8;
        mcount    += 8;
      end else begin
        bus.push_valid = 1'b0;
      end
      mcount--;
      exp_val++;
      tick();
      checks++;
      if (bus.count !== 5'(mcount)) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", c, bus.count, mcount); end
    end
    idle();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", bus.count); end
    checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL clear_pop_valid got=%b exp=0", bus.pop_valid); end
  endtask

  task automatic test_merge();
    logic [3:0] exp_m [8] = '{4'h9, 4'hB, 4'h2, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB};
    bus.push_valid = 1'b1;
    bus.push_data  = 32'h2490_0000;
    tick();
    bus.push_valid = 1'b0;
    bus.pop_en     = 1'b1;
    repeat (5) tick();
    bus.pop_en     = 1'b0;
    checks++; if (bus.count !== 5'd3) begin failures++; $display("FAIL merge_pre_count got=%0d exp=3", bus.count); end
    bus.merge_en   = 1'b1;
    bus.merge_data = 32'hBBBB_BBBB;
    bus.push_valid = 1'b1;
    bus.push_data  = 32'h1111_1111;
    #1;
    checks++; if (bus.push_ready !== 1'b0) begin failures++; $display("FAIL merge_push_ready got=%b exp=0", bus.push_ready); end
    tick();
    idle();
    checks++; if (bus.count !== 5'd8) begin failures++; $display("FAIL merge_count got=%0d exp=8", bus.count); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.pop_data !== exp_m[k]) begin failures++; $display("FAIL merge_pop[%0d] got=%h exp=%h", k, bus.pop_data, exp_m[k]); end
      bus.pop_en = 1'b1;
      tick();
    end
    bus.pop_en = 1'b0;
    checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL merge_drain_valid got=%b exp=0", bus.pop_valid); end
  endtask

  task automatic test_merge_pop();
    logic [3:0] exp_m [8] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA};
    bus.push_valid = 1'b1;
    bus.push_data  = 32'h4444_4444;
    tick();
    bus.push_valid = 1'b0;
    bus.pop_en     = 1'b1;
    repeat (3) tick();
    checks++; if (bus.count !== 5'd5) begin failures++; $display("FAIL mpop_pre_count got=%0d exp=5", bus.count); end
    bus.merge_en   = 1'b1;
    bus.merge_data = 32'hA976_5321;
    tick();
    idle();
    checks++; if (bus.count !== 5'd8) begin failures++; $display("FAIL mpop_count got=%0d exp=8", bus.count); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.pop_data !== exp_m[k]) begin failures++; $display("FAIL mpop_pop[%0d] got=%h exp=%h", k, bus.pop_data, exp_m[k]); end
      bus.pop_en = 1'b1;
      tick();
    end
    bus.pop_en     = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = 32'h1111_1111;
    tick();
    checks++; if (bus.count !== 5'd8) begin failures++; $display("FAIL prio_pre_count got=%0d exp=8", bus.count); end
    bus.clear      = 1'b1;
    bus.merge_en   = 1'b1;
    bus.merge_data = 32'h3333_3333;
    tick();
    idle();
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL prio_clear_count got=%0d exp=0", bus.count); end
    checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL prio_clear_valid got=%b exp=0", bus.pop_valid); end
  endtask

  task automatic test_async_reset();
    bus.push_valid = 1'b1;
    bus.push_data  = seq_row(0);
    tick();
    bus.push_data  = seq_row(8);
    tick();
    bus.push_valid = 1'b0;
    bus.pop_en     = 1'b1;
    repeat (7) tick();
    bus.pop_en     = 1'b0;
    checks++; if (bus.count !== 5'd9) begin failures++; $display("FAIL arst_pre_count got=%0d exp=9", bus.count); end
    #2;
    rstN = 1'b0;
    #1;
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", bus.count); end
    checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL arst_pop_valid got=%b exp=0", bus.pop_valid); end
    checks++; if (bus.pop_data !== 4'h0) begin failures++; $display("FAIL arst_pop_data got=%h exp=0", bus.pop_data); end
    checks++; if (bus.push_ready !== 1'b1) begin failures++; $display("FAIL arst_push_ready got=%b exp=1", bus.push_ready); end
    @(negedge clk);
    rstN = 1'b1;
    tick();
    bus.push_valid = 1'b1;
    bus.push_data  = 32'hCDEF_0123;
    tick();
    bus.push_valid = 1'b0;
    checks++; if (bus.count !== 5'd8) begin failures++; $display("FAIL arst_push_count got=%0d exp=8", bus.count); end
    checks++; if (bus.pop_data !== 4'h3) begin failures++; $display("FAIL arst_pop0 got=%h exp=3", bus.pop_data); end
    bus.pop_en = 1'b1;
    tick();
    bus.pop_en = 1'b0;
    checks++; if (bus.pop_data !== 4'h2) begin failures++; $display("FAIL arst_pop1 got=%h exp=2", bus.pop_data); end
    checks++; if (bus.count !== 5'd7) begin failures++; $display("FAIL arst_pop_count got=%0d exp=7", bus.count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_merge();
    test_merge_pop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pixel_fifo.md
# pixel_fifo

Parametrised pixel FIFO for the PPU draw pipeline. It replaces the plain single-entry FIFO with a tile-row-wide bulk push, a single-pixel pop, a synchronous clear, and a sprite-overlay merge. One instance serves as the background FIFO and one as the sprite FIFO. The PPU fetcher pushes or merges 8-pixel rows, and the LCD pixel stage pops one pixel per cycle.

## Interface
- DataWidth, 4: bits per entry; bits [ColorBits-1:0] are the colour index.
- ColorBits, 2: width of the colour field; colour 0 means transparent.
- Depth, 16: entry count; power of two, ≥ PushWidth.
- PushWidth, 8: entries per push/merge (one tile row).
- clk  in  1  clock.
- rstN  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous flush (end of line, window start).
- push_valid  in  1  request to append PushWidth entries.
- push_data  in  PushWidth*DataWidth  row to append; slice [DataWidth-1:0] is the oldest (leftmost) pixel.
- push_ready  out  1  high when free entries ≥ PushWidth and merge_en is low.
- merge_en  in  1  overlay a sprite row onto the head of the FIFO.
- merge_data  in  PushWidth*DataWidth  sprite row, same slice order as push_data.
- pop_en  in  1  consume the head entry.
- pop_data  out  DataWidth  head entry (show-ahead); 0 when empty.
- pop_valid  out  1  count ≠ 0.
- count  out  $clog2(Depth+1)  current occupancy.

## Operation
- Storage is a circular buffer with pointers head and tail, each $clog2(Depth) bits, wrapping modulo Depth. Occupancy is kept in a separate count register.
- Push: when push_valid && push_ready, entry i of push_data is written to tail+i, tail advances by PushWidth, and count increases by PushWidth. A push while push_ready is low is dropped with no state change.
- Pop: when pop_en && pop_valid, head advances by 1 and count decreases by 1. A pop while empty is ignored.
- Merge:
  - For i in 0..PushWidth-1, with the base at the post-pop head, slot = base+i.
  - If i < post-pop count, the slot is overwritten with merge_data[i] only when the existing entry's colour field is 0. Otherwise the existing entry is kept (first sprite wins).
  - If i ≥ post-pop count, the slot is written unconditionally.
  - The new count is max(post-pop count, PushWidth); tail is adjusted to match.
- Precedence within one cycle: clear > merge > push. Pop combines with push or merge in the same cycle.
- Clear: head, tail and count go to 0. Stored entries are not scrubbed.

## Timing
- All state updates on posedge clk. pop_data, pop_valid and push_ready are combinational from registered state.
- A push is visible at pop_data on the next cycle if the FIFO was empty.
- Push + pop in the same cycle: count changes by +PushWidth−1. push_ready is evaluated on pre-pop occupancy, so a pop does not free space for a push in the same cycle.
- Merge + pop in the same cycle: the pop consumes the old head, and the merge aligns to the new head.
- A merge occurring with a push in the same cycle takes effect; the push is not accepted (push_ready is low).
- Reset (async assert, sync-safe deassert): head = tail = count = 0, pop_valid = 0, pop_data = 0, push_ready = 1. Reset mid-operation discards all contents.
- Throughput: 1 pop per cycle sustained; 1 push per cycle while space allows.

## Structure
- ppu_pkg holds:
  - the pixel_t typedef {bg_priority, palette, color[1:0]} and the COLOR_TRANSPARENT constant;
  - PPU_ROW_PIXELS = 8 and the default FIFO depth.
- The merge comparison is replicated PushWidth times. It is a natural sub-module: pixel_merge_lane (combinational; inputs existing entry, incoming entry, in_range; output selected entry).
- The FIFO core stays in pixel_fifo; no further hierarchy.

## Test plan
- Reset then idle: count = 0, pop_valid = 0, pop_data = 0, push_ready = 1. Asserting pop_en changes nothing.
- Push rows 0x0–0x7 then 0x8–0xF: count = 16, push_ready = 0. A third push is dropped. 16 pops return 0x0..0xF in order, then pop_valid = 0.
- Push one row, then pop every cycle while pushing a new row each time count ≤ 8, across 64 cycles: output is a contiguous sequence with no gaps; head and tail wrap past 15 correctly.
- Sprite FIFO holds 3 entries, colours {1,0,2}; merge a row of colour 3: head three become {1,3,2}, entries 3–7 become 3, count = 8.
- Same cycle: count = 5, pop_en + merge_en, all-colour-0 existing: merge aligns to the new head and count = 8. Then in one cycle clear + push_valid + merge_en: count = 0.
- Drop rstN asynchronously with count = 9, mid-clock: outputs return to reset values immediately; first push after release is popped correctly.
